// File: rtl/cache_dma_pkg.sv
// Shared types and helpers for the cache block DMA engine and its bus packet format.
package cache_dma_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StResp
  } cache_dma_state_e;

  localparam int unsigned WordBits = 32;

  // Bus packet is {we, addr[31:0], wdata[data_words*32-1:0]}, we in the MSB.
  function automatic int unsigned cache_bus_pkt_width(input int unsigned data_words);
    return 1 + 32 + data_words * WordBits;
  endfunction

  function automatic int unsigned block_offset_bits(input int unsigned block_words);
    return $clog2(block_words * 4);
  endfunction

endpackage

// File: rtl/cache_dma.sv
// Block fill/writeback engine: splits one cache block request into bus beats,
// reassembles returned read beats and hands the block back to the cache.
module cache_dma
  import cache_dma_pkg::*;
#(
  parameter int unsigned block_width_p = 4,
  parameter int unsigned dma_data_width_p = 1,
  localparam int unsigned cache_bus_pkt_width_lp = cache_bus_pkt_width(dma_data_width_p)
) (
  input  logic                                clk_i,
  input  logic                                nreset_i,
  input  logic                                req_valid_i,
  output logic                                req_ready_o,
  input  logic                                req_we_i,
  input  logic [31:0]                         req_addr_i,
  input  logic [block_width_p*WordBits-1:0]   req_wdata_i,
  output logic                                resp_valid_o,
  input  logic                                resp_yumi_i,
  output logic [block_width_p*WordBits-1:0]   resp_data_o,
  output logic                                cb_valid_o,
  input  logic                                cb_yumi_i,
  output logic [cache_bus_pkt_width_lp-1:0]   cb_pkt_o,
  input  logic                                cb_valid_i,
  input  logic [dma_data_width_p*WordBits-1:0] cb_data_i
);

  localparam int unsigned beats_lp = block_width_p / dma_data_width_p;
  localparam int unsigned cnt_w_lp = $clog2(beats_lp) + 1;
  localparam int unsigned beat_bits_lp = dma_data_width_p * WordBits;
  localparam int unsigned off_lp = block_offset_bits(block_width_p);
  localparam logic [31:0] align_mask_lp = ~((32'd1 << off_lp) - 32'd1);
  localparam logic [31:0] beat_bytes_lp = 32'(dma_data_width_p * 4);
  localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(beats_lp - 1);
  localparam logic [cnt_w_lp-1:0] all_beats_lp = cnt_w_lp'(beats_lp);

  if (block_width_p % dma_data_width_p != 0) begin : g_bad_cfg
    $error("cache_dma: dma_data_width_p must divide block_width_p");
  end

  typedef struct packed {
    logic                    we;
    logic [31:0]             addr;
    logic [beat_bits_lp-1:0] wdata;
  } cache_bus_pkt_t;

  cache_dma_state_e state_q, state_d;
  logic                              we_q;
  logic [31:0]                       addr_q;
  logic [block_width_p*WordBits-1:0] wdata_q, data_q;
  logic [cnt_w_lp-1:0]               tx_cnt_q, rx_cnt_q;
  logic                              accept, tx_fire, rx_fire, rx_last;
  cache_bus_pkt_t                    pkt;

  assign accept  = req_valid_i & req_ready_o;
  assign tx_fire = (state_q == StIssue) & cb_yumi_i;
  // Return beats only count while a read is in flight and the block is not yet full.
  assign rx_fire = cb_valid_i & ~we_q & ((state_q == StIssue) | (state_q == StDrain))
                 & (rx_cnt_q != all_beats_lp);
  assign rx_last = rx_fire & (rx_cnt_q == last_beat_lp);

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we_i;
        addr_q   <= req_addr_i & align_mask_lp;
        wdata_q  <= req_wdata_i;
        tx_cnt_q <= '0;
        rx_cnt_q <= '0;
      end else begin
        if (tx_fire) tx_cnt_q <= tx_cnt_q + cnt_w_lp'(1);
        if (rx_fire) begin
          rx_cnt_q <= rx_cnt_q + cnt_w_lp'(1);
          data_q[rx_cnt_q*beat_bits_lp +: beat_bits_lp] <= cb_data_i;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: begin
        if (tx_fire && (tx_cnt_q == last_beat_lp)) begin
          if (we_q || (rx_cnt_q == all_beats_lp) || rx_last) state_d = StResp;
          else state_d = StDrain;
        end
      end
      StDrain: if (rx_last) state_d = StResp;
      StResp:  if (resp_yumi_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pkt.we    = we_q;
    pkt.addr  = addr_q + 32'(tx_cnt_q) * beat_bytes_lp;
    pkt.wdata = wdata_q[tx_cnt_q*beat_bits_lp +: beat_bits_lp];
  end

  assign req_ready_o  = (state_q == StIdle);
  assign cb_valid_o   = (state_q == StIssue);
  assign resp_valid_o = (state_q == StResp);
  assign cb_pkt_o     = pkt;
  assign resp_data_o  = data_q;

  stray_beat_a : assert property (@(posedge clk_i) disable iff (!nreset_i)
    cb_valid_i |-> (!we_q && ((state_q == StIssue) || (state_q == StDrain))))
    else $error("cache_dma: cb_valid_i outside an active read");

endmodule

// File: doc/cache_dma.md
Name: cache_dma

Overview:
- Per-cache block transfer engine between a cache controller's miss/evict logic and the shared bus.
- Splits each block fill (read) or writeback (write) into block_width_p/dma_data_width_p bus beats.
- Issues beats as cache_bus_pkt_t packets on the bus's valid/yumi interface, counts returned read beats, assembles the full block and hands it back to the cache.
- One outstanding block request per instance; beats within a request are pipelined.

Parameters:
- block_width_p, 4, words per cache block.
- dma_data_width_p, 1, words per bus beat; must divide block_width_p.
- beats_lp (localparam), block_width_p/dma_data_width_p, beats per block.
- cache_bus_pkt_width_lp (localparam), `cache_bus_pkt_width(dma_data_width_p), packet width.

Ports:
- clk_i  in  1  single clock.
- nreset_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  cache block request valid.
- req_ready_o  out  1  engine idle, request accepted when req_valid_i & req_ready_o.
- req_we_i  in  1  1 = writeback, 0 = fill.
- req_addr_i  in  32  byte address; low $clog2(block_width_p*4) bits forced to 0.
- req_wdata_i  in  block_width_p*32  writeback block, word 0 in LSBs.
- resp_valid_o  out  1  request complete; read data valid.
- resp_yumi_i  in  1  cache consumes response.
- resp_data_o  out  block_width_p*32  assembled fill block; don't-care for writes.
- cb_valid_o  out  1  bus packet valid.
- cb_yumi_i  in  1  bus accepted packet this cycle.
- cb_pkt_o  out  cache_bus_pkt_width_lp  {we, addr, wdata} per cache_bus_pkt_t.
- cb_valid_i  in  1  read beat returned from bus.
- cb_data_i  in  dma_data_width_p*32  returned beat data.

Behaviour:
- Reset (nreset_i low, async): state IDLE, tx_cnt = rx_cnt = 0.
  - Outputs during reset: cb_valid_o 0, resp_valid_o 0, req_ready_o 1.
  - resp_data_o buffer cleared to 0.
- States: IDLE, ISSUE, DRAIN, RESP. req_ready_o = (state==IDLE); cb_valid_o = (state==ISSUE); resp_valid_o = (state==RESP).
- IDLE:
  - On accept, latch we, aligned addr and wdata; clear counters; go to ISSUE.
  - cb_valid_o rises the cycle after accept.
- ISSUE:
  - cb_pkt_o.we = latched we.
  - cb_pkt_o.addr = base + tx_cnt*dma_data_width_p*4.
  - cb_pkt_o.wdata = latched word slice tx_cnt.
  - The packet must stay stable while cb_yumi_i is low. On cb_yumi_i, tx_cnt++.
  - On acceptance of the last beat (tx_cnt==beats_lp-1 & cb_yumi_i):
    - write → RESP;
    - read with all beats received, counting a same-cycle cb_valid_i → RESP;
    - otherwise → DRAIN.
- Read data capture:
  - Valid in ISSUE or DRAIN. On cb_valid_i, write cb_data_i into buffer slice rx_cnt, then rx_cnt++.
  - Beats return in issue order.
  - tx and rx increments in the same cycle are legal and independent.
- DRAIN: on the cb_valid_i that brings rx_cnt to beats_lp → RESP.
- RESP: hold resp_valid_o and resp_data_o until resp_yumi_i, then → IDLE. req_ready_o is 0 during RESP, so there are no back-to-back accepts.
- cb_valid_i is ignored in IDLE/RESP and for writes; sim assertion fires if it occurs.
- Counters are $clog2(beats_lp)+1 bits wide and never wrap within a request.
- Latency:
  - Write, yumi always high: resp_valid_o at accept + beats_lp + 1.
  - Read: last data beat + 1.
- Reset mid-operation drops the request: outputs go to reset values immediately, and late returning beats are ignored.
- Elaboration assertion: block_width_p % dma_data_width_p == 0.

Decomposition:
- cache.svh / shared package holds:
  - cache_bus_pkt_t via `declare_cache_bus_pkt_t;
  - cache_dma_state_e enum {IDLE, ISSUE, DRAIN, RESP};
  - the block-offset-bits constant macro.
- No sub-module required. The tx/rx counters are inline up-counters; a shared `dma_beat_counter` is optional if reused elsewhere.

Test Plan:
- Write, beats_lp=4, addr 0x10C, wdata words {D,C,B,A}, yumi always 1 → pkts at addr 0x100/0x104/0x108/0x10C, we=1, wdata A,B,C,D on cycles 1-4; resp_valid_o on cycle 5.
- Read, addr 0x200, memory returns 0x11,0x22,0x33,0x44 two cycles after each yumi → resp_data_o = {0x44,0x33,0x22,0x11}; resp_valid_o the cycle after the last return.
- Backpressure: cb_yumi_i low 3 cycles on beat 1 → cb_pkt_o unchanged (addr base+4) and tx_cnt held; then completes normally.
- Final tx yumi and final rx return in the same cycle (zero-latency memory) → direct ISSUE→RESP, no DRAIN cycle.
- nreset_i low after 2 read beats issued → cb_valid_o 0 and req_ready_o 1 immediately; stray cb_valid_i afterwards does not change resp_data_o; a new request works.
- dma_data_width_p=4, block_width_p=4 → single beat; write completes at accept+2; read completes the cycle after return.
